// File: rtl/seg_pkg.sv
// Shared definitions for the parallel-to-serial segment framer:
// the controller state encoding and the bit positions inside sout.
package seg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        CLEAR,
        DONE
    } state_t;

    localparam int SOUT_CLK = 3;
    localparam int SOUT_CLR = 2;
    localparam int SOUT_DT  = 1;
    localparam int SOUT_EN  = 0;

endpackage

// File: rtl/clk_div_tick.sv
// Half-period timer: while enabled, pulses tick once every CLK_DIV cycles.
// Dropping en restarts the count so every new phase gets a full half-period.
module clk_div_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/par2ser_framer.sv
// Serialises a parallel word onto a 4-wire segment link {clk, clr, dt, en},
// retransmitting on request or whenever the word changes.
module par2ser_framer
    import seg_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int CLK_DIV     = 1,
    parameter int MSB_FIRST   = 1,
    parameter int AUTO_UPDATE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    input  logic             clr_req,
    output logic [3:0]       sout,
    output logic             busy,
    output logic             done
);

    localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] last_sent;
    logic [BW-1:0]    bit_cnt;
    logic             pend_load;
    logic             pend_clr;
    logic             tick;
    logic             div_en;
    logic             start_frame;
    logic             start_clear;
    logic             advance;
    logic             cur_bit;
    logic [WIDTH-1:0] shreg_shifted;

    assign div_en = (state == SHIFT_LO) || (state == SHIFT_HI) || (state == CLEAR);

    clk_div_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .tick  (tick)
    );

    assign cur_bit       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign shreg_shifted = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A clear always wins in IDLE; bit_cnt doubles as the half-period index inside CLEAR.
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        start_clear = 1'b0;
        advance     = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req || pend_clr) begin
                    state_nxt   = CLEAR;
                    start_clear = 1'b1;
                end else if (load || pend_load || (AUTO_UPDATE != 0 && data != last_sent)) begin
                    state_nxt   = SHIFT_LO;
                    start_frame = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (tick) state_nxt = SHIFT_HI;
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = SHIFT_LO;
                        advance   = 1'b1;
                    end
                end
            end
            CLEAR: begin
                if (tick && bit_cnt != '0) state_nxt = IDLE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sout           = '0;
        sout[SOUT_CLK] = (state == SHIFT_HI);
        sout[SOUT_CLR] = (state != CLEAR);
        sout[SOUT_DT]  = ((state == SHIFT_LO) || (state == SHIFT_HI)) ? cur_bit : 1'b0;
        sout[SOUT_EN]  = 1'b1;
        busy           = (state != IDLE);
        done           = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            last_sent <= '0;
            bit_cnt   <= '0;
        end else if (start_frame) begin
            shreg     <= data;
            last_sent <= data;
            bit_cnt   <= '0;
        end else if (start_clear) begin
            last_sent <= '0;
            bit_cnt   <= '0;
        end else if (advance) begin
            shreg   <= shreg_shifted;
            bit_cnt <= bit_cnt + 1'b1;
        end else if (state == CLEAR && tick) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // Requests seen while busy collapse into one pending flag each; a load that
    // loses to a simultaneous clear in IDLE is parked the same way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_load <= 1'b0;
            pend_clr  <= 1'b0;
        end else if (state == IDLE) begin
            if (start_clear) begin
                pend_clr <= 1'b0;
                if (load) pend_load <= 1'b1;
            end else if (start_frame) begin
                pend_load <= 1'b0;
            end
        end else begin
            if (load)    pend_load <= 1'b1;
            if (clr_req) pend_clr  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_par2ser_framer.sv
// Directed bench for par2ser_framer: two 8-bit instances (MSB-first and LSB-first)
// share stimulus while a negedge monitor records edges, bits and pulse timing.
module tb_par2ser_framer;

    localparam int I_CLK = 3;
    localparam int I_CLR = 2;
    localparam int I_DT  = 1;

    logic       clk;
    logic       rst_n;
    logic [7:0] data;
    logic       load;
    logic       clr_req;
    logic [3:0] sout_a, sout_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int n_cmp;
    int n_err;

    par2ser_framer #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1), .AUTO_UPDATE(1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .data(data), .load(load), .clr_req(clr_req),
        .sout(sout_a), .busy(busy_a), .done(done_a)
    );

    par2ser_framer #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(0), .AUTO_UPDATE(1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .data(data), .load(load), .clr_req(clr_req),
        .sout(sout_b), .busy(busy_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  so [2];
    logic        bz [2];
    logic        dn [2];
    assign so[0] = sout_a;
    assign so[1] = sout_b;
    assign bz[0] = busy_a;
    assign bz[1] = busy_b;
    assign dn[0] = done_a;
    assign dn[1] = done_b;

    int          cyc;
    int          rise_cnt  [2];
    logic [31:0] bits      [2];
    int          hold_viol [2];
    int          busy_cnt  [2];
    int          start_cnt [2];
    int          start_cyc [2][4];
    int          done_cnt  [2];
    int          done_cyc  [2][4];
    int          clr_cnt   [2];
    int          clr_first [2];
    logic        prev_clk  [2];
    logic        prev_dt   [2];
    logic        prev_busy [2];

    // Every negedge: collect seg_dt at each seg_clk rise plus busy/done/clear timing.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (so[d][I_CLK] && !prev_clk[d]) begin
                bits[d] = {bits[d][30:0], so[d][I_DT]};
                rise_cnt[d]++;
            end
            if (so[d][I_CLK] && prev_clk[d] && so[d][I_DT] !== prev_dt[d]) hold_viol[d]++;
            if (bz[d]) busy_cnt[d]++;
            if (bz[d] && !prev_busy[d]) begin
                if (start_cnt[d] < 4) start_cyc[d][start_cnt[d]] = cyc;
                start_cnt[d]++;
            end
            if (dn[d]) begin
                if (done_cnt[d] < 4) done_cyc[d][done_cnt[d]] = cyc;
                done_cnt[d]++;
            end
            if (!so[d][I_CLR]) begin
                if (clr_cnt[d] == 0) clr_first[d] = cyc;
                clr_cnt[d]++;
            end
            prev_clk[d]  = so[d][I_CLK];
            prev_dt[d]   = so[d][I_DT];
            prev_busy[d] = bz[d];
        end
    end

    task automatic clear_mon();
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            rise_cnt[d]  = 0;
            bits[d]      = '0;
            hold_viol[d] = 0;
            busy_cnt[d]  = 0;
            start_cnt[d] = 0;
            done_cnt[d]  = 0;
            clr_cnt[d]   = 0;
            clr_first[d] = -1;
            for (int k = 0; k < 4; k++) begin
                start_cyc[d][k] = -1;
                done_cyc[d][k]  = -1;
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data = 8'h00; load = 1'b0; clr_req = 1'b0;
        for (int d = 0; d < 2; d++) begin
            prev_clk[d] = 1'b0; prev_dt[d] = 1'b0; prev_busy[d] = 1'b0;
        end
        clear_mon();
        wait_cyc(3);
        n_cmp++; if (sout_a !== 4'b0101) begin n_err++; $display("[TB] FAIL reset_sout_msb: got %b want 0101", sout_a); end
        n_cmp++; if (sout_b !== 4'b0101) begin n_err++; $display("[TB] FAIL reset_sout_lsb: got %b want 0101", sout_b); end
        n_cmp++; if ({busy_a, done_a, busy_b, done_b} !== 4'b0000) begin n_err++; $display("[TB] FAIL reset_busy_done: got %b want 0000", {busy_a, done_a, busy_b, done_b}); end
        rst_n = 1'b1;
        clear_mon();
        wait_cyc(5);
        n_cmp++; if (busy_cnt[0] !== 0) begin n_err++; $display("[TB] FAIL idle_after_reset: busy cycles %0d want 0", busy_cnt[0]); end
    endtask

    task automatic test_msb_first();
        clear_mon();
        data = 8'hA5; load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
        wait_cyc(39);
        n_cmp++; if (rise_cnt[0] !== 8) begin n_err++; $display("[TB] FAIL a5_rises: got %0d want 8", rise_cnt[0]); end
        n_cmp++; if (bits[0][7:0] !== 8'hA5) begin n_err++; $display("[TB] FAIL a5_msb_bits: got %h want a5", bits[0][7:0]); end
        n_cmp++; if (bits[1][7:0] !== 8'hA5) begin n_err++; $display("[TB] FAIL a5_lsb_bits: got %h want a5", bits[1][7:0]); end
        n_cmp++; if (busy_cnt[0] !== 33) begin n_err++; $display("[TB] FAIL a5_busy_len: got %0d want 33", busy_cnt[0]); end
        n_cmp++; if (done_cyc[0][0] !== 33) begin n_err++; $display("[TB] FAIL a5_done_cycle: got %0d want 33", done_cyc[0][0]); end
        n_cmp++; if (done_cnt[0] !== 1) begin n_err++; $display("[TB] FAIL a5_done_count: got %0d want 1", done_cnt[0]); end
        n_cmp++; if (hold_viol[0] + hold_viol[1] !== 0) begin n_err++; $display("[TB] FAIL a5_dt_hold: got %0d changes want 0", hold_viol[0] + hold_viol[1]); end
    endtask

    task automatic test_lsb_first();
        clear_mon();
        data = 8'h01;
        wait_cyc(40);
        n_cmp++; if (rise_cnt[1] !== 8) begin n_err++; $display("[TB] FAIL x01_lsb_rises: got %0d want 8", rise_cnt[1]); end
        n_cmp++; if (bits[1][7:0] !== 8'h80) begin n_err++; $display("[TB] FAIL x01_lsb_bits: got %h want 80", bits[1][7:0]); end
        n_cmp++; if (bits[0][7:0] !== 8'h01) begin n_err++; $display("[TB] FAIL x01_msb_bits: got %h want 01", bits[0][7:0]); end
    endtask

    task automatic test_auto_update();
        data = 8'h00;
        wait_cyc(40);
        clear_mon();
        data = 8'h3C;
        wait_cyc(40);
        n_cmp++; if (start_cnt[0] !== 1) begin n_err++; $display("[TB] FAIL auto_frames: got %0d want 1", start_cnt[0]); end
        n_cmp++; if (rise_cnt[0] !== 8) begin n_err++; $display("[TB] FAIL auto_rises: got %0d want 8", rise_cnt[0]); end
        n_cmp++; if (bits[0][7:0] !== 8'h3C) begin n_err++; $display("[TB] FAIL auto_bits: got %h want 3c", bits[0][7:0]); end
        clear_mon();
        wait_cyc(200);
        n_cmp++; if (rise_cnt[0] + rise_cnt[1] !== 0) begin n_err++; $display("[TB] FAIL auto_quiet_rises: got %0d want 0", rise_cnt[0] + rise_cnt[1]); end
        n_cmp++; if (busy_cnt[0] !== 0) begin n_err++; $display("[TB] FAIL auto_quiet_busy: got %0d want 0", busy_cnt[0]); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        data = 8'hFF; load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_cyc(4);
            load = 1'b1;
            wait_cyc(1);
            load = 1'b0;
        end
        wait_cyc(64);
        n_cmp++; if (start_cnt[0] !== 2) begin n_err++; $display("[TB] FAIL b2b_frames: got %0d want 2", start_cnt[0]); end
        n_cmp++; if (rise_cnt[0] !== 16) begin n_err++; $display("[TB] FAIL b2b_rises: got %0d want 16", rise_cnt[0]); end
        n_cmp++; if (bits[0][15:0] !== 16'hFFFF) begin n_err++; $display("[TB] FAIL b2b_bits: got %h want ffff", bits[0][15:0]); end
        n_cmp++; if (done_cyc[0][0] !== 33) begin n_err++; $display("[TB] FAIL b2b_done1: got %0d want 33", done_cyc[0][0]); end
        n_cmp++; if (start_cyc[0][1] !== 35) begin n_err++; $display("[TB] FAIL b2b_restart: got %0d want 35", start_cyc[0][1]); end
        n_cmp++; if (done_cyc[0][1] !== 67) begin n_err++; $display("[TB] FAIL b2b_done2: got %0d want 67", done_cyc[0][1]); end
    endtask

    task automatic test_clear_priority();
        clear_mon();
        data = 8'h00; load = 1'b1; clr_req = 1'b1;
        wait_cyc(1);
        load = 1'b0; clr_req = 1'b0;
        wait_cyc(49);
        n_cmp++; if (clr_cnt[0] !== 4) begin n_err++; $display("[TB] FAIL clr_low_len: got %0d want 4", clr_cnt[0]); end
        n_cmp++; if (clr_first[0] !== 1) begin n_err++; $display("[TB] FAIL clr_low_start: got %0d want 1", clr_first[0]); end
        n_cmp++; if (start_cyc[0][1] !== 6) begin n_err++; $display("[TB] FAIL clr_frame_start: got %0d want 6", start_cyc[0][1]); end
        n_cmp++; if (rise_cnt[0] !== 8) begin n_err++; $display("[TB] FAIL clr_frame_rises: got %0d want 8", rise_cnt[0]); end
        n_cmp++; if (busy_cnt[0] !== 37) begin n_err++; $display("[TB] FAIL clr_busy_len: got %0d want 37", busy_cnt[0]); end
        n_cmp++; if (done_cyc[1][0] !== 38) begin n_err++; $display("[TB] FAIL clr_done_cycle: got %0d want 38", done_cyc[1][0]); end
    endtask

    task automatic test_reset_mid_frame();
        clear_mon();
        data = 8'h81; load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
        wait_cyc(15);
        n_cmp++; if (rise_cnt[0] !== 4) begin n_err++; $display("[TB] FAIL mid_rises_before: got %0d want 4", rise_cnt[0]); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (sout_a !== 4'b0101) begin n_err++; $display("[TB] FAIL mid_reset_sout: got %b want 0101", sout_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("[TB] FAIL mid_reset_busy: got %b want 0", busy_a); end
        wait_cyc(3);
        n_cmp++; if (rise_cnt[0] !== 4) begin n_err++; $display("[TB] FAIL mid_rises_during: got %0d want 4", rise_cnt[0]); end
        clear_mon();
        rst_n = 1'b1;
        wait_cyc(40);
        n_cmp++; if (rise_cnt[0] !== 8) begin n_err++; $display("[TB] FAIL post_reset_rises: got %0d want 8", rise_cnt[0]); end
        n_cmp++; if (bits[0][7:0] !== 8'h81) begin n_err++; $display("[TB] FAIL post_reset_bits: got %h want 81", bits[0][7:0]); end
        n_cmp++; if (done_cnt[0] !== 1) begin n_err++; $display("[TB] FAIL post_reset_done: got %0d want 1", done_cnt[0]); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        @(negedge clk);
        #1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_auto_update();
        test_back_to_back();
        test_clear_priority();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/par2ser_framer.md
PAR2SER_FRAMER -- requirements
Module: par2ser_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, meaning number of bits per serial frame (range 2..256).
REQ-002 SHALL have parameter CLK_DIV, default 1, meaning clk cycles per serial-clock half-period (range 1..255).
REQ-003 SHALL have parameter MSB_FIRST, default 1, meaning 1 shifts data[WIDTH-1] first and 0 shifts data[0] first.
REQ-004 SHALL have parameter AUTO_UPDATE, default 1, meaning 1 starts a frame automatically whenever data differs from the last frame sent.
REQ-005 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port data, input, WIDTH, parallel word to transmit.
REQ-008 SHALL have port load, input, 1, single-cycle request to transmit data regardless of change.
REQ-009 SHALL have port clr_req, input, 1, request to pulse the external register clear.
REQ-010 SHALL have port sout, output, 4, {seg_clk, seg_clr, seg_dt, seg_en} in that bit order (3 down to 0).
REQ-011 SHALL have port busy, output, 1, high while a frame or clear is in progress.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at frame end.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT_LO, SHIFT_HI, CLEAR, DONE.
REQ-014 SHALL define start condition in IDLE as load=1, or AUTO_UPDATE=1 and data != last_sent.
REQ-015 SHALL, on the edge a start is accepted in IDLE: capture data into the shift register and last_sent, set bit_cnt=0, and enter SHIFT_LO.
REQ-016 SHALL, in SHIFT_LO, hold seg_clk=0 and seg_dt=current bit for CLK_DIV cycles, then enter SHIFT_HI.
REQ-017 SHALL, in SHIFT_HI, hold seg_clk=1 with seg_dt unchanged for CLK_DIV cycles, then either advance the shifter and return to SHIFT_LO, or enter DONE after bit WIDTH-1.
REQ-018 SHALL keep seg_dt stable across each seg_clk rising edge, with at least CLK_DIV cycles of setup and hold.
REQ-019 SHALL produce exactly WIDTH seg_clk rising edges per frame, with a frame length of 2*CLK_DIV*WIDTH cycles from SHIFT_LO entry to DONE entry.
REQ-020 SHALL assert done for exactly the single DONE cycle, then return to IDLE.
REQ-021 SHALL drive busy=1 in SHIFT_LO, SHIFT_HI, CLEAR and DONE, and busy=0 in IDLE.
REQ-022 SHALL, on a load or clr_req arriving while busy, set a one-deep pending flag, coalescing multiple requests into one.
REQ-023 SHALL service a pending load from IDLE on the cycle after DONE, using data as sampled at that edge.
REQ-024 SHALL, on clr_req in IDLE (or pending), enter CLEAR, drive seg_clr=0 for 2*CLK_DIV cycles, set last_sent=0, then return to IDLE.
REQ-025 SHALL give clr_req priority over load when both are present on the same edge, with load left pending.
REQ-026 SHALL, with AUTO_UPDATE=1, ignore a data change during a frame until IDLE, then retransmit if data != last_sent.
REQ-027 SHALL hold seg_clk=0 and seg_dt=0 in IDLE, CLEAR and DONE.
REQ-028 SHALL drive seg_clr=1 except in CLEAR, and seg_en=1 at all times out of reset.
REQ-029 SHALL size all counters as $clog2 of their maximum count plus 1, with no wrap-around inside a frame.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously force state=IDLE, shift register=0, last_sent=0, bit_cnt=0, div_cnt=0 and pending flags=0.
REQ-031 SHALL, during reset, hold outputs at seg_clk=0, seg_clr=1, seg_dt=0, seg_en=1, busy=0 and done=0.
REQ-032 SHALL abort a frame on reset mid-operation with no further seg_clk edges, and after release SHALL start a fresh frame if AUTO_UPDATE=1 and data != 0.

Structure
REQ-033 SHALL place the FSM state enum and the sout bit-index constants in shared package seg_pkg.
REQ-034 SHALL implement the half-period timer as sub-module clk_div_tick, with parameter CLK_DIV, inputs clk, rst_n and en, and a one-cycle tick output.
REQ-035 SHALL keep the FSM, shifter and counters in par2ser_framer.

Verification
REQ-036 SHALL verify: WIDTH=8, CLK_DIV=2, MSB_FIRST=1, data=8'hA5 with a load pulse -> seg_dt at 8 seg_clk rises = 1,0,1,0,0,1,0,1; busy high 33 cycles; done at cycle 33.
REQ-037 SHALL verify: MSB_FIRST=0 with data=8'hA5 -> seg_dt sequence 1,0,1,0,0,1,0,1 (bit0 first), and data=8'h01 -> first bit 1 with remaining bits 0.
REQ-038 SHALL verify: AUTO_UPDATE=1 with data changing 8'h00->8'h3C -> one frame with no load; data unchanged afterwards -> no further seg_clk edges for 200 cycles.
REQ-039 SHALL verify: load repeated 3 times mid-frame with data=8'hFF -> exactly one extra frame, starting the cycle after done, with 8 ones.
REQ-040 SHALL verify: clr_req and load on the same IDLE edge -> seg_clr low 4 cycles, then a full frame of data.
REQ-041 SHALL verify: rst_n low at bit 3 -> seg_clk=0 immediately; after release with data=8'h81 -> fresh 8-bit frame with done pulse.
